// File: rtl/debounce_scheduler.sv
// Debouncer for N_INPUTS pins sharing one 32-bit delay counter via round-robin.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer on every input.
module debounce_scheduler #(
   parameter int          N_INPUTS      = 4,
   parameter int unsigned TIME_DEBOUNCE = 50_000_000
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [N_INPUTS-1:0]         signal_i,
   output logic [N_INPUTS-1:0]         signal_o,
   output logic [N_INPUTS-1:0]         press_o,
   output logic                        busy_o,
   output logic [$clog2(N_INPUTS)-1:0] grant_o
);

   localparam int          GW       = $clog2(N_INPUTS);
   localparam logic [GW:0] NW       = (GW+1)'(N_INPUTS);
   localparam logic [31:0] CNT_LAST = 32'(TIME_DEBOUNCE - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_COUNT  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   logic [1:0]          state;
   logic [31:0]         cnt;
   logic [GW-1:0]       ptr;
   logic [N_INPUTS-1:0] in_lvl;
   logic [N_INPUTS-1:0] req;
   logic                found;
   logic [GW-1:0]       pick;
   logic [GW:0]         sum;

`ifdef DEBOUNCE_SYNC_EN
   logic [N_INPUTS-1:0] sync_q1;
   logic [N_INPUTS-1:0] sync_q2;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= signal_i;
         sync_q2 <= sync_q1;
      end
   end

   assign in_lvl = sync_q2;
`else
   assign in_lvl = signal_i;
`endif

   assign req    = in_lvl ^ signal_o;
   assign busy_o = (state != ST_IDLE);

   // Search upward from ptr+1, wrapping, so the last winner goes to the back.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      for (int k = 1; k <= N_INPUTS; k++) begin
         sum = {1'b0, ptr} + (GW+1)'(k);
         if (sum >= NW)
            sum = sum - NW;
         if (!found && req[sum[GW-1:0]]) begin
            found = 1'b1;
            pick  = sum[GW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         ptr      <= GW'(N_INPUTS - 1);
         grant_o  <= '0;
         signal_o <= '0;
         press_o  <= '0;
      end else begin
         press_o <= '0;
         unique case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (found) begin
                  grant_o <= pick;
                  ptr     <= pick;
                  state   <= ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (!req[grant_o]) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= ST_COMMIT;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            ST_COMMIT: begin
               state             <= ST_IDLE;
               cnt               <= '0;
               signal_o[grant_o] <= ~signal_o[grant_o];
               press_o[grant_o]  <= ~signal_o[grant_o];
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
